// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: default width, op codes, FSM states.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_MULTU = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_SLTU  = 3'b101;
  localparam logic [2:0] OP_SUB   = 3'b110;
  localparam logic [2:0] OP_SLT   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative one-bit-per-cycle datapath: shift-add unsigned multiply and, when
// SEQ_ALU_DIV_EN is defined, restoring unsigned divide. A start pulse loads the
// operands; finish_o is high during the last iteration, and lo_o/hi_o then
// carry the final product (low/high) or quotient/remainder.
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             finish_o
);

  localparam int              CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  // acc holds the running upper product / partial remainder,
  // lo holds the multiplier shifting out / dividend shifting into the quotient.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc, mul_lo;
  logic [WIDTH-1:0] step_acc, step_lo;

  // One shift-add step: add multiplicand when the current multiplier bit is set, then shift right.
  always_comb begin
    mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    mul_acc = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
  end

`ifdef SEQ_ALU_DIV_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;
  logic             fits;
  logic [WIDTH-1:0] div_acc, div_lo;

  // One restoring-division step; when the shifted remainder fits, the true
  // difference is below the divisor so its low WIDTH bits are exact.
  always_comb begin
    rem_sh   = {acc_q, lo_q[WIDTH-1]};
    rem_diff = rem_sh[WIDTH-1:0] - opb_q;
    fits     = (rem_sh >= {1'b0, opb_q});
    div_acc  = fits ? rem_diff : rem_sh[WIDTH-1:0];
    div_lo   = {lo_q[WIDTH-2:0], fits};
    step_acc = div_q ? div_acc : mul_acc;
    step_lo  = div_q ? div_lo : mul_lo;
  end
`else
  logic unused_div_sel;
  assign unused_div_sel = is_div_i;

  // Multiply-only build: the step is always shift-add.
  always_comb begin
    step_acc = mul_acc;
    step_lo  = mul_lo;
  end
`endif

  // Load on start, otherwise iterate while running and stop after WIDTH steps.
  always_comb begin
    acc_d = acc_q;
    lo_d  = lo_q;
    opb_d = opb_q;
    cnt_d = cnt_q;
    run_d = run_q;
`ifdef SEQ_ALU_DIV_EN
    div_d = div_q;
`endif
    if (start_i) begin
      acc_d = '0;
      lo_d  = a_i;
      opb_d = b_i;
      cnt_d = '0;
      run_d = 1'b1;
`ifdef SEQ_ALU_DIV_EN
      div_d = is_div_i;
`endif
    end else if (run_q) begin
      acc_d = step_acc;
      lo_d  = step_lo;
      if (cnt_q == LAST) begin
        run_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      lo_q  <= '0;
      opb_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      div_q <= 1'b0;
`endif
    end else begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
      opb_q <= opb_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
`ifdef SEQ_ALU_DIV_EN
      div_q <= div_d;
`endif
    end
  end

  assign finish_o = run_q && (cnt_q == LAST);
  assign lo_o     = step_lo;
  assign hi_o     = step_acc;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU top: IDLE/RUN/DONE control FSM, single-cycle logic/arith ops,
// and the iterative multiply/divide unit. The divider exists only when
// SEQ_ALU_DIV_EN is defined; otherwise op 100 behaves as ADD and div_zero stays 0.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] alu_res;
  logic             is_div_op;
  logic             md_start, md_is_div, md_finish;
  logic [WIDTH-1:0] md_lo, md_hi;

`ifdef SEQ_ALU_DIV_EN
  assign is_div_op = (op == OP_DIVU);
`else
  assign is_div_op = 1'b0;
`endif

  // Single-cycle results; every code not listed (including MULTU/DIVU) falls back to ADD.
  always_comb begin
    alu_res = a + b;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SUB:  alu_res = a - b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_res = a + b;
    endcase
  end

  // Next-state and result capture; operands are only looked at in IDLE on start.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    hi_d      = hi_q;
    dz_d      = dz_q;
    md_start  = 1'b0;
    md_is_div = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dz_d = 1'b0;
          if (op == OP_MULTU) begin
            md_start = 1'b1;
            state_d  = S_RUN;
          end else if (is_div_op) begin
            if (b == '0) begin
              result_d = '1;
              hi_d     = a;
              dz_d     = 1'b1;
              state_d  = S_DONE;
            end else begin
              md_start  = 1'b1;
              md_is_div = 1'b1;
              state_d   = S_RUN;
            end
          end else begin
            result_d = alu_res;
            hi_d     = '0;
            state_d  = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (md_finish) begin
          result_d = md_lo;
          hi_d     = md_hi;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      hi_q     <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      dz_q     <= dz_d;
    end
  end

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (md_start),
    .is_div_i (md_is_div),
    .a_i      (a),
    .b_i      (b),
    .lo_o     (md_lo),
    .hi_o     (md_hi),
    .finish_o (md_finish)
  );

  assign result   = result_q;
  assign hi       = hi_q;
  assign div_zero = dz_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=32 and WIDTH=8. Stimulus pushes the
// expected outcome (from an arithmetic reference model) into a per-instance
// queue; a monitor pops and compares whenever done is seen.
module tb_seq_alu;

  logic clk;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    logic [2:0]  o;
    logic [63:0] r;
    logic [63:0] h;
    logic        dz;
    int          lat;
    int          acc;
  } exp_t;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int          W       = (gi == 0) ? 32 : 8;
    localparam logic [63:0] MASK    = (64'd1 << W) - 64'd1;
    localparam int          RST_CYC = (W >= 16) ? 10 : W / 2;

    logic         rst, start;
    logic [2:0]   op;
    logic [W-1:0] a, b, result, hi;
    logic         busy, done, div_zero;
    bit           fin_g = 1'b0;
    exp_t         q[$];

    seq_alu #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .result   (result),
      .hi       (hi),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero)
    );

    // Reference behaviour from the arithmetic definition of each op.
    function automatic exp_t model(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
      exp_t        e;
      longint      sx, sy;
      logic [127:0] p;
      e.o = o; e.r = '0; e.h = '0; e.dz = 1'b0; e.lat = 1; e.acc = 0;
      case (o)
        3'b000: e.r = x & y;
        3'b001: e.r = x | y;
        3'b110: e.r = (x - y) & MASK;
        3'b111: begin
          sx = x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
          sy = y[W-1] ? longint'(y) - (longint'(1) << W) : longint'(y);
          e.r = (sx < sy) ? 64'd1 : 64'd0;
        end
        3'b101: e.r = (x < y) ? 64'd1 : 64'd0;
        3'b011: begin
          p     = 128'(x) * 128'(y);
          e.r   = p[63:0] & MASK;
          e.h   = 64'(p >> W) & MASK;
          e.lat = W + 1;
        end
        3'b100: begin
`ifdef SEQ_ALU_DIV_EN
          if (y == 64'd0) begin
            e.r = MASK; e.h = x; e.dz = 1'b1;
          end else begin
            e.r = x / y; e.h = x % y; e.lat = W + 1;
          end
`else
          e.r = (x + y) & MASK;
`endif
        end
        default: e.r = (x + y) & MASK;
      endcase
      return e;
    endfunction

    // Called just after a rising edge; returns just after the last edge with start high.
    task automatic issue(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                         input bit expect_it, input int hold);
      int   guard;
      exp_t e;
      guard = 0;
      while (busy !== 1'b0 && guard < 100) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 100) note_fail($sformatf("w%0d_busy_wait", W));
      start = 1'b1; op = o; a = x[W-1:0]; b = y[W-1:0];
      if (expect_it) begin
        e     = model(o, x & MASK, y & MASK);
        e.acc = cyc + 1;
        q.push_back(e);
      end
      @(posedge clk); #1;
      for (int i = 0; i < hold; i++) begin
        op = 3'($urandom); a = W'($urandom); b = W'($urandom);
        @(posedge clk); #1;
      end
      start = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin : mon
      exp_t e;
      forever begin
        @(negedge clk);
        if (done === 1'b1) begin
          if (q.size() == 0) begin
            note_fail($sformatf("w%0d_unexpected_done", W));
          end else begin
            e = q.pop_front();
            chk($sformatf("w%0d_op%b_result", W, e.o), 64'(result), e.r);
            chk($sformatf("w%0d_op%b_hi", W, e.o), 64'(hi), e.h);
            chk($sformatf("w%0d_op%b_div_zero", W, e.o), 64'(div_zero), 64'(e.dz));
            chk($sformatf("w%0d_op%b_latency", W, e.o), 64'(cyc - e.acc + 1), 64'(e.lat));
            chk($sformatf("w%0d_op%b_busy_in_done", W, e.o), 64'(busy), 64'd1);
            $display("[W=%0d] op=%b result=%h hi=%h div_zero=%b latency=%0d",
                     W, e.o, result, hi, div_zero, cyc - e.acc + 1);
          end
        end
      end
    end

    initial begin : stim
      logic [2:0]  d_op [8];
      logic [63:0] d_a  [8];
      logic [63:0] d_b  [8];
      logic [2:0]  ro;
      logic [63:0] rx, ry;
      int          mode, guard;

      d_op = '{3'b111, 3'b101, 3'b011, 3'b100, 3'b100, 3'b010, 3'b110, 3'b011};
      d_a  = '{64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'd100, 64'd100, 64'hFF, 64'h0, 64'hFF};
      d_b  = '{64'h1, 64'h1, 64'hFFFFFFFF, 64'd7, 64'd0, 64'h2, 64'h1, 64'hFF};

      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk($sformatf("w%0d_reset_result", W), 64'(result), 64'd0);
      chk($sformatf("w%0d_reset_hi", W), 64'(hi), 64'd0);
      chk($sformatf("w%0d_reset_busy", W), 64'(busy), 64'd0);
      chk($sformatf("w%0d_reset_done", W), 64'(done), 64'd0);
      chk($sformatf("w%0d_reset_div_zero", W), 64'(div_zero), 64'd0);
      @(posedge clk); #1;

      // Directed corner cases (wide values wrap to the narrow width).
      for (int i = 0; i < 8; i++) issue(d_op[i], d_a[i], d_b[i], 1'b1, 0);

      // start held through the whole multiply while operands keep changing.
      issue(3'b011, 64'h1234_5678 & MASK, 64'h9ABC_DEF0 & MASK, 1'b1, W + 1);

      // Reset in the middle of RUN: no done, outputs cleared, then a fresh ADD.
`ifdef SEQ_ALU_DIV_EN
      issue(3'b100, 64'd100, 64'd7, 1'b0, 0);
`else
      issue(3'b011, 64'd100, 64'd7, 1'b0, 0);
`endif
      repeat (RST_CYC - 1) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk($sformatf("w%0d_abort_result", W), 64'(result), 64'd0);
      chk($sformatf("w%0d_abort_hi", W), 64'(hi), 64'd0);
      chk($sformatf("w%0d_abort_busy", W), 64'(busy), 64'd0);
      chk($sformatf("w%0d_abort_done", W), 64'(done), 64'd0);
      chk($sformatf("w%0d_abort_div_zero", W), 64'(div_zero), 64'd0);
      @(posedge clk); #1;
      issue(3'b010, 64'd3, 64'd4, 1'b1, 0);

      // Random traffic with biased operands and occasional ignored extra start cycles.
      for (int n = 0; n < 40; n++) begin
        ro   = 3'($urandom_range(0, 7));
        rx   = {$urandom, $urandom};
        ry   = {$urandom, $urandom};
        mode = $urandom_range(0, 4);
        case (mode)
          1: ry = 64'd0;
          2: rx = MASK;
          3: ry = 64'($urandom_range(1, 15));
          4: ry = rx;
          default: ;
        endcase
        issue(ro, rx & MASK, ry & MASK, 1'b1, $urandom_range(0, 1));
      end

      guard = 0;
      while (q.size() != 0 && guard < 200) begin
        @(posedge clk);
        guard++;
      end
      chk($sformatf("w%0d_queue_drained", W), 64'(q.size()), 64'd0);
      fin_g = 1'b1;
    end
  end

  initial begin
    int i;
    i = 0;
    while (!(g_inst[0].fin_g && g_inst[1].fin_g) && i < 80000) begin
      @(posedge clk);
      i++;
    end
    if (!(g_inst[0].fin_g && g_inst[1].fin_g)) note_fail("global_timeout");
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: operand/result width in bits (legal range 8..64).
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port start  input  1  request; accepted only when busy=0.
REQ-005 SHALL provide port op  input  3  operation code: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed), 101 SLTU, 011 MULTU, 100 DIVU.
REQ-006 SHALL provide ports a, b  input  WIDTH  operands, sampled on acceptance only.
REQ-007 SHALL provide port result  output  WIDTH  registered primary result.
REQ-008 SHALL provide port hi  output  WIDTH  registered upper product or remainder.
REQ-009 SHALL provide port busy  output  1  high while an operation is in flight.
REQ-010 SHALL provide port done  output  1  single-cycle pulse; result/hi valid from this cycle until the next acceptance.
REQ-011 SHALL provide port div_zero  output  1  sticky-per-op flag, set with done when DIVU has b=0.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; IDLE->DONE on single-cycle op accept, IDLE->RUN on MULTU/DIVU accept, RUN->DONE after WIDTH iterations, DONE->IDLE unconditionally.
REQ-013 SHALL capture a, b, op at acceptance; later input changes have no effect on the operation in flight.
REQ-014 SHALL give single-cycle ops (AND/OR/ADD/SUB/SLT/SLTU) latency 1: done high in the cycle after acceptance, busy high for that cycle only.
REQ-015 SHALL wrap ADD/SUB modulo 2^WIDTH, no overflow flag; hi=0 for all single-cycle ops.
REQ-016 SHALL set SLT result=1 iff a<b as two's-complement (e.g. a=-1, b=1 -> 1); SLTU result=1 iff a<b unsigned; upper bits zero.
REQ-017 SHALL compute MULTU by iterative shift-add, one bit per cycle: {hi,result} = a*b unsigned (2*WIDTH bits); done WIDTH+1 cycles after acceptance.
REQ-018 SHALL compute DIVU by restoring division, one bit per cycle: result=quotient, hi=remainder; done WIDTH+1 cycles after acceptance.
REQ-019 SHALL, for DIVU with b=0, skip RUN: result=all ones, hi=a, div_zero=1, done one cycle after acceptance.
REQ-020 SHALL clear div_zero on every acceptance.
REQ-021 SHALL ignore start while busy=1 (no queuing, no error); start in the DONE cycle is ignored, earliest re-accept is the cycle after done.
REQ-022 SHALL treat undefined op codes as ADD.
REQ-023 SHALL hold result/hi/div_zero stable in IDLE.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, force IDLE and set result=0, hi=0, busy=0, done=0, div_zero=0, iteration counter=0.
REQ-025 SHALL let rst abort an operation in RUN with no done pulse; rst has priority over start in the same cycle.

Configuration
REQ-026 SHALL compile the divider only when macro SEQ_ALU_DIV_EN is defined.
REQ-027 SHALL, without SEQ_ALU_DIV_EN, treat op 100 as ADD (latency 1) and tie div_zero to 0; all other behaviour is unchanged.

Structure
REQ-028 SHALL place op-code constants, the state enum and WIDTH default in shared package alu_pkg.
REQ-029 SHALL isolate the iterative multiply/divide datapath in sub-module seq_muldiv (operands, start, op select in; product/quotient/remainder, finish out); the FSM and single-cycle ops stay in seq_alu.

Verification
REQ-030 SHALL check SLT: WIDTH=32, a=0xFFFFFFFF, b=0x00000001, op=111 -> done next cycle, result=1; op=101 -> result=0.
REQ-031 SHALL check MULTU: a=0xFFFFFFFF, b=0xFFFFFFFF -> done at cycle 33 after accept, hi=0xFFFFFFFE, result=0x00000001.
REQ-032 SHALL check DIVU: a=100, b=7 -> done at cycle 33, result=14, hi=2, div_zero=0; b=0 -> done at cycle 1, result=0xFFFFFFFF, hi=100, div_zero=1.
REQ-033 SHALL check busy handling: start held high during MULTU with changing a/b -> exactly one done, result from first operands.
REQ-034 SHALL check reset mid-RUN: rst at cycle 10 of DIVU -> no done, all outputs 0 next cycle, new ADD 3+4 -> result=7 one cycle after accept.
REQ-035 SHALL check wrap-around and width: WIDTH=8, ADD 0xFF+0x02 -> 0x01; SUB 0x00-0x01 -> 0xFF; MULTU 0xFF*0xFF -> hi=0xFE, result=0x01 at cycle 9.
